// File: rtl/data_memory_unit.sv
// Multi-cycle data memory: byte/half/word loads and stores with fixed wait states,
// little-endian lanes, alignment error detection and sign/zero extension.
module data_memory_unit #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  output logic [31:0] mem_data,
  output logic        busy,
  output logic        done,
  output logic        access_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int LA_W  = IDX_W + 2;
  localparam logic [3:0] CNT_LOAD = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_reg, state_next;
  logic [3:0]      cnt_reg, cnt_next;
  logic [LA_W-1:0] addr_reg;
  logic [31:0]     wdata_reg;
  logic [1:0]      size_reg;
  logic            unsigned_reg;
  logic            store_reg;
  logic [31:0]     mem_data_reg;

  // Storage is zero at time zero only; reset never touches it.
  logic [31:0] mem_reg [DEPTH_WORDS] = '{default: 32'h0};

  logic            req;
  logic            accept;
  logic            commit;
  logic [LA_W-1:0] cur_addr;
  logic [31:0]     cur_wdata;
  logic [1:0]      cur_size;
  logic            cur_unsigned;
  logic            cur_store;
  logic            cur_err;
  logic [IDX_W-1:0] cur_idx;
  logic [3:0]      byte_en;
  logic [31:0]     lane_wdata;
  logic [31:0]     rd_word;
  logic [7:0]      rd_bytes [4];
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [31:0]     ld_value;
  logic            unused_addr_bits;

  // Address bits above the array size are intentionally dropped (wrap-around).
  assign unused_addr_bits = ^addr[31:LA_W];

  assign req    = mem_read | mem_write;
  assign accept = (state_reg == IDLE) && req;

  // In IDLE the live inputs describe the request (needed when WAIT_CYCLES is 0);
  // afterwards the latched copy does.
  always_comb begin
    cur_addr     = addr_reg;
    cur_wdata    = wdata_reg;
    cur_size     = size_reg;
    cur_unsigned = unsigned_reg;
    cur_store    = store_reg;
    if (state_reg == IDLE) begin
      cur_addr     = addr[LA_W-1:0];
      cur_wdata    = write_data;
      cur_size     = size;
      cur_unsigned = unsigned_ld;
      cur_store    = mem_write;
    end
  end

  always_comb begin
    cur_err = 1'b0;
    case (cur_size)
      2'b00:   cur_err = 1'b0;
      2'b01:   cur_err = cur_addr[0];
      2'b10:   cur_err = |cur_addr[1:0];
      default: cur_err = 1'b1;
    endcase
  end

  assign cur_idx = cur_addr[LA_W-1:2];
  assign rd_word = mem_reg[cur_idx];

  for (genvar gi = 0; gi < 4; gi++) begin : g_rd_lane
    assign rd_bytes[gi] = rd_word[8*gi +: 8];
  end

  assign ld_byte = rd_bytes[cur_addr[1:0]];
  assign ld_half = cur_addr[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    ld_value = 32'h0;
    if (!cur_err) begin
      case (cur_size)
        2'b00:   ld_value = {{24{~cur_unsigned & ld_byte[7]}}, ld_byte};
        2'b01:   ld_value = {{16{~cur_unsigned & ld_half[15]}}, ld_half};
        2'b10:   ld_value = rd_word;
        default: ld_value = 32'h0;
      endcase
    end
  end

  // Store data is replicated across lanes so byte enables alone select the target.
  always_comb begin
    byte_en    = 4'b0000;
    lane_wdata = cur_wdata;
    case (cur_size)
      2'b00: begin
        byte_en    = 4'b0001 << cur_addr[1:0];
        lane_wdata = {4{cur_wdata[7:0]}};
      end
      2'b01: begin
        byte_en    = cur_addr[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{cur_wdata[15:0]}};
      end
      2'b10:   byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (req) begin
          if (WAIT_CYCLES == 0) begin
            state_next = DONE;
          end else begin
            state_next = WAIT;
            cnt_next   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_reg == 4'd0) begin
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The access takes effect on the edge that enters DONE.
  assign commit = (state_next == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= 4'd0;
      addr_reg     <= '0;
      wdata_reg    <= 32'h0;
      size_reg     <= 2'b00;
      unsigned_reg <= 1'b0;
      store_reg    <= 1'b0;
      mem_data_reg <= 32'h0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        addr_reg     <= addr[LA_W-1:0];
        wdata_reg    <= write_data;
        size_reg     <= size;
        unsigned_reg <= unsigned_ld;
        store_reg    <= mem_write;
      end
      if (commit && !cur_store) begin
        mem_data_reg <= ld_value;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && commit && cur_store && !cur_err) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) begin
          mem_reg[cur_idx][8*i +: 8] <= lane_wdata[8*i +: 8];
        end
      end
    end
  end

  assign mem_data   = mem_data_reg;
  assign busy       = (state_reg != IDLE);
  assign done       = (state_reg == DONE);
  assign access_err = (state_reg == DONE) && cur_err;

endmodule
